bsg_min_gap_issuer: RTL and testbench



---
 rtl/bsg_min_gap_pkg.sv | 16 +
 rtl/bsg_min_gap_ctr.sv | 29 ++
 rtl/bsg_min_gap_issuer.sv | 95 +++++++++
 tb/tb_bsg_min_gap_issuer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_min_gap_pkg.sv
// Shared types and limits for the minimum-gap issuer.
package bsg_min_gap_pkg;

  typedef enum logic {
    eReady = 1'b0,
    eGap   = 1'b1
  } bsg_min_gap_state_e;

  localparam int unsigned max_cycles_lp = 65535;

  // A counter that only ever holds 0 still needs one bit.
  function automatic int unsigned ctr_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bsg_min_gap_ctr.sv
// Loadable saturating down-counter that times the quiet period between issues.
module bsg_min_gap_ctr #(
  parameter int unsigned width_p     = 1,
  parameter int unsigned load_val_p  = 0,
  parameter int unsigned reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  output logic               zero_o,
  output logic [width_p-1:0] ctr_o
);

  logic [width_p-1:0] r_ctr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ctr <= width_p'(reset_val_p);
    end else if (load_i) begin
      r_ctr <= width_p'(load_val_p);
    end else if (r_ctr != '0) begin
      r_ctr <= r_ctr - 1'b1;
    end
  end

  assign ctr_o  = r_ctr;
  assign zero_o = (r_ctr == '0);

endmodule

// File: rtl/bsg_min_gap_issuer.sv
// Single-entry buffer that issues downstream with a guaranteed idle gap between handshakes.
//   state  | meaning
//   eReady | gap expired, a held item may be offered downstream
//   eGap   | quiet period running, downstream valid suppressed
module bsg_min_gap_issuer
  import bsg_min_gap_pkg::*;
#(
  parameter int unsigned width_p      = 32,
  parameter int unsigned cycles_p     = 16,
  parameter bit          reset_wait_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               busy_o
);

  localparam int unsigned ctr_width_lp = ctr_width(cycles_p);
  localparam int unsigned reset_val_lp = reset_wait_p ? cycles_p : 0;

  if (cycles_p > max_cycles_lp) begin : g_bad_cycles
    $error("bsg_min_gap_issuer: cycles_p exceeds supported maximum");
  end

  bsg_min_gap_state_e        r_state;
  bsg_min_gap_state_e        w_state_n;
  logic                      r_full;
  logic [width_p-1:0]        r_data;
  logic                      w_enq;
  logic                      w_deq;
  logic                      w_zero;
  logic [ctr_width_lp-1:0]   w_ctr;

  assign ready_o = ~r_full & ~reset_i;
  assign v_o     = r_full & (r_state == eReady) & ~reset_i;
  assign busy_o  = ~w_zero & ~reset_i;
  assign data_o  = r_data;

  // Gating yumi with v_o makes an illegal consume a no-op.
  assign w_enq = v_i & ready_o;
  assign w_deq = yumi_i & v_o;

  bsg_min_gap_ctr #(
    .width_p    (ctr_width_lp),
    .load_val_p (cycles_p),
    .reset_val_p(reset_val_lp)
  ) u_ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (w_deq),
    .zero_o (w_zero),
    .ctr_o  (w_ctr)
  );

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      eReady: if (w_deq && (cycles_p != 0)) w_state_n = eGap;
      eGap:   if (w_ctr == ctr_width_lp'(1)) w_state_n = eReady;
      default: w_state_n = eReady;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= (reset_val_lp != 0) ? eGap : eReady;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_full <= 1'b0;
    end else if (w_enq) begin
      r_full <= 1'b1;
    end else if (w_deq) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_data <= data_i;
    end
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_min_gap_issuer.sv
// Drives three issuer configurations with directed and random traffic; scoreboard checks payload order.
module tb_bsg_min_gap_issuer;

  localparam int N    = 3;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        v_in  [N];
  logic        yumi  [N];
  logic        rdy   [N];
  logic        v_out [N];
  logic        busy  [N];
  logic [63:0] din   [N];
  logic [7:0]  dout0;
  logic [63:0] dout1;
  logic [0:0]  dout2;

  bsg_min_gap_issuer #(.width_p(8), .cycles_p(4), .reset_wait_p(1'b1)) u_a (
    .clk_i(clk), .reset_i(rst[0]), .v_i(v_in[0]), .data_i(din[0][7:0]), .ready_o(rdy[0]),
    .v_o(v_out[0]), .data_o(dout0), .yumi_i(yumi[0]), .busy_o(busy[0]));

  bsg_min_gap_issuer #(.width_p(64), .cycles_p(0), .reset_wait_p(1'b0)) u_b (
    .clk_i(clk), .reset_i(rst[1]), .v_i(v_in[1]), .data_i(din[1]), .ready_o(rdy[1]),
    .v_o(v_out[1]), .data_o(dout1), .yumi_i(yumi[1]), .busy_o(busy[1]));

  bsg_min_gap_issuer #(.width_p(1), .cycles_p(3), .reset_wait_p(1'b0)) u_c (
    .clk_i(clk), .reset_i(rst[2]), .v_i(v_in[2]), .data_i(din[2][0:0]), .ready_o(rdy[2]),
    .v_o(v_out[2]), .data_o(dout2), .yumi_i(yumi[2]), .busy_o(busy[2]));

  function automatic int gap_of(input int i);
    case (i) 0: return 4; 1: return 0; default: return 3; endcase
  endfunction
  function automatic int rw_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic logic [63:0] mask_of(input int i);
    case (i) 0: return 64'hFF; 1: return '1; default: return 64'h1; endcase
  endfunction
  function automatic int min_space(input int i);
    return (gap_of(i) + 1 > 2) ? gap_of(i) + 1 : 2;
  endfunction
  // Hand-derived cycle of the first consume after the initial 3-cycle reset.
  function automatic int first_yumi_exp(input int i);
    case (i) 0: return 7; 1: return 4; default: return 4; endcase
  endfunction
  function automatic logic [63:0] get_dout(input int i);
    case (i) 0: return {56'b0, dout0}; 1: return dout1; default: return {63'b0, dout2}; endcase
  endfunction

  logic [63:0] q0[$], q1[$], q2[$];

  function automatic void q_push(input int i, input logic [63:0] d);
    case (i) 0: q0.push_back(d); 1: q1.push_back(d); default: q2.push_back(d); endcase
  endfunction
  function automatic int q_size(input int i);
    case (i) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic logic [63:0] q_pop(input int i);
    case (i) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction
  function automatic void q_clear(input int i);
    case (i) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake must deliver the oldest accepted payload.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (v_out[i] === 1'b1 && yumi[i] === 1'b1) begin
          if (q_size(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty inst%0d: got handshake with data %0h expected none", i, get_dout(i));
          end else begin
            check($sformatf("data_o inst%0d", i), get_dout(i), q_pop(i));
          end
        end
      end
    end
  end

  bit          m_full   [N];
  int          ready_at [N];
  int          last_y   [N];
  int          first_y  [N];
  int          hold     [N];
  bit          rst_done [N];
  logic [63:0] seq      [N];
  bit          exp_v    [N];
  bit          exp_r    [N];
  bit          exp_b    [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; v_in[i] = 1'b0; yumi[i] = 1'b0; din[i] = '0;
      m_full[i] = 1'b0; ready_at[i] = 0; last_y[i] = -1; first_y[i] = -1;
      hold[i] = 0; rst_done[i] = 1'b0; seq[i] = '0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        bit r, dv, dy;
        r = (c < 3);
        if (c >= 100 && c < 150 && !rst_done[i] && m_full[i] && (gap_of(i) == 0 || c < ready_at[i])) begin
          r = 1'b1;
          rst_done[i] = 1'b1;
        end
        if (c >= 150 && $urandom_range(199) == 0) r = 1'b1;

        exp_v[i] = !r && m_full[i] && (c >= ready_at[i]);
        exp_r[i] = !r && !m_full[i];
        exp_b[i] = !r && (c < ready_at[i]);

        dv = 1'b0;
        dy = 1'b0;
        if ((c >= 3 && c < 60) || (c >= 100 && c < 150)) begin
          dv = 1'b1;
          dy = exp_v[i];
        end else if (c >= 60 && c < 100) begin
          dv = 1'b1;
          if (exp_v[i]) begin
            if (hold[i] < 10) hold[i]++;
            else begin dy = 1'b1; hold[i] = 0; end
          end
        end else if (c >= 150) begin
          dv = ($urandom_range(1) == 1);
          dy = exp_v[i] && ($urandom_range(1) == 1);
        end
        rst[i]  = r;
        v_in[i] = dv;
        yumi[i] = dy;
        din[i]  = (c >= 150) ? {$urandom, $urandom} : seq[i];
      end

      #1;
      for (int i = 0; i < N; i++) begin
        check($sformatf("ready_o inst%0d c%0d", i, c), {63'b0, rdy[i]},   {63'b0, exp_r[i]});
        check($sformatf("v_o inst%0d c%0d", i, c),     {63'b0, v_out[i]}, {63'b0, exp_v[i]});
        check($sformatf("busy_o inst%0d c%0d", i, c),  {63'b0, busy[i]},  {63'b0, exp_b[i]});

        if (rst[i]) begin
          m_full[i]   = 1'b0;
          ready_at[i] = c + 1 + (rw_of(i) != 0 ? gap_of(i) : 0);
          last_y[i]   = -1;
          q_clear(i);
        end else if (yumi[i] && exp_v[i]) begin
          if (first_y[i] < 0) first_y[i] = c;
          if (last_y[i] >= 0) begin
            checks++;
            if (c - last_y[i] < min_space(i)) begin
              errors++;
              $display("FAIL yumi_spacing inst%0d c%0d: got %0d cycles required >= %0d", i, c, c - last_y[i], min_space(i));
            end
            if (c < 60) begin
              check($sformatf("stream_spacing inst%0d c%0d", i, c), 64'(c - last_y[i]), 64'(min_space(i)));
            end
          end
          last_y[i]   = c;
          m_full[i]   = 1'b0;
          ready_at[i] = c + 1 + gap_of(i);
        end else if (v_in[i] && exp_r[i]) begin
          m_full[i] = 1'b1;
          q_push(i, din[i] & mask_of(i));
          seq[i] = seq[i] + 64'd1;
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      v_in[i] = 1'b0; yumi[i] = 1'b0; rst[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      check($sformatf("first_yumi inst%0d", i), 64'(first_y[i]), 64'(first_yumi_exp(i)));
      check($sformatf("leftover inst%0d", i), 64'(q_size(i)), {63'b0, m_full[i]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
